// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD,
    ST_RMW_RD,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bytes touched by an access; only funct3[1:0] matters for size.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
// slave = the load/store unit, master = pipeline plus data memory.
interface lsu_mem_port_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rd_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_wr_data, mem_read, mem_write
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_wr_data, mem_read, mem_write
  );

endinterface

// File: rtl/lsu_load_extend.sv
// Combinational sign/zero extension of the low byte/halfword of a load word.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{i_word[7]}}, i_word[7:0]};
      F3_H:    o_data = {{16{i_word[15]}}, i_word[15:0]};
      F3_BU:   o_data = {24'h000000, i_word[7:0]};
      F3_HU:   o_data = {16'h0000, i_word[15:0]};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store unit: range/encoding checks, load extension, SB/SH as
// read-modify-write. Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
)
(
  input  logic           clk,
  input  logic           rst,
  lsu_mem_port_if.slave  bus
);

  lsu_state_e  r_state;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_mem_wr_data;

  logic        w_illegal;
  logic        w_range_err;
  logic        w_misalign;
  logic        w_err;
  logic [32:0] w_end;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

  assign w_illegal = bus.req_we ? (bus.req_funct3 > F3_W)
                                : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);

  // 33-bit sum so an address near 2^32 wrapping past zero still counts as out of range.
  assign w_end       = {1'b0, bus.req_addr} + {30'b0, access_size(bus.req_funct3)};
  assign w_range_err = w_end > 33'(MEM_BYTES);

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_illegal | w_range_err | w_misalign;

  lsu_load_extend u_load_extend (
    .i_funct3 (r_funct3),
    .i_word   (bus.mem_rd_data),
    .o_data   (w_ext)
  );

  // Merge happens as the read word arrives, so the WR state drives a ready word.
  assign w_merge = r_funct3[0] ? {bus.mem_rd_data[31:16], r_wdata[15:0]}
                               : {bus.mem_rd_data[31:8],  r_wdata[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_funct3      <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_wr_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_funct3    <= bus.req_funct3;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_state      <= ST_RESP;
            end else if (!bus.req_we) begin
              r_mem_read <= 1'b1;
              r_state    <= ST_LD;
            end else if (bus.req_funct3 == F3_W) begin
              r_mem_write   <= 1'b1;
              r_mem_wr_data <= bus.req_wdata;
              r_state       <= ST_WR;
            end else begin
              r_mem_read <= 1'b1;
              r_state    <= ST_RMW_RD;
            end
          end
        end
        ST_LD: begin
          r_mem_read   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_ext;
          r_state      <= ST_RESP;
        end
        ST_RMW_RD: begin
          r_mem_read    <= 1'b0;
          r_mem_write   <= 1'b1;
          r_mem_wr_data <= w_merge;
          r_state       <= ST_WR;
        end
        ST_WR: begin
          r_mem_write   <= 1'b0;
          r_mem_wr_data <= '0;
          r_resp_valid  <= 1'b1;
          r_state       <= ST_RESP;
        end
        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_err    = r_resp_err;
  assign bus.resp_rdata  = r_resp_rdata;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wr_data = r_mem_wr_data;
  // Strobes are gated by rst so an aborted WR never reaches memory.
  assign bus.mem_read    = r_mem_read & ~rst;
  assign bus.mem_write   = r_mem_write & ~rst;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed table-driven bench for lsu_mem_port with a byte-addressed memory model.
module tb_lsu_mem_port;

  localparam int unsigned MEMB = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_port_if ifc();

  lsu_mem_port #(.MEM_BYTES(MEMB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  logic [7:0] mem [0:MEMB-1] = '{default: 8'h00};

  always_comb begin
    logic [31:0] a;
    ifc.mem_rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      a = ifc.mem_addr + 32'(i);
      if (a < MEMB) ifc.mem_rd_data[8*i +: 8] = mem[a[9:0]];
    end
  end

  always @(posedge clk) begin
    logic [31:0] a;
    if (ifc.mem_write) begin
      for (int i = 0; i < 4; i++) begin
        a = ifc.mem_addr + 32'(i);
        if (a < MEMB) mem[a[9:0]] <= ifc.mem_wr_data[8*i +: 8];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wr_exp;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic err,
                              input logic [31:0] rdata, input logic [31:0] wr_exp);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.wr_exp = wr_exp;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int k, lat, rd_cnt, wr_cnt, rd_k, wr_k;
    int exp_lat, exp_rd_k, exp_wr_k;
    logic rmw, done, addr_bad, wd_bad, got_err;
    logic [31:0] got_rdata, got_wd;
    rmw = v.we && (v.f3 != 3'b010);
    exp_lat  = v.err ? 1 : (rmw ? 3 : 2);
    exp_rd_k = (!v.err && (!v.we || rmw)) ? 1 : 0;
    exp_wr_k = (!v.err && v.we) ? (rmw ? 2 : 1) : 0;
    k = 0; lat = 0; rd_cnt = 0; wr_cnt = 0; rd_k = 0; wr_k = 0;
    done = 1'b0; addr_bad = 1'b0; wd_bad = 1'b0; got_err = 1'b0;
    got_rdata = '0; got_wd = '0;

    @(negedge clk);
    chk($sformatf("v%0d_ready_pre", idx), 32'(ifc.req_ready), 32'd1);
    ifc.req_valid  = 1'b1;
    ifc.req_we     = v.we;
    ifc.req_funct3 = v.f3;
    ifc.req_addr   = v.addr;
    ifc.req_wdata  = v.wdata;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    while (!done && k < 6) begin
      k++;
      if (ifc.mem_read) begin
        rd_cnt++;
        if (rd_k == 0) rd_k = k;
        if (ifc.mem_addr !== v.addr) addr_bad = 1'b1;
      end
      if (ifc.mem_write) begin
        wr_cnt++;
        wr_k = k;
        got_wd = ifc.mem_wr_data;
        if (ifc.mem_addr !== v.addr) addr_bad = 1'b1;
      end else if (ifc.mem_wr_data !== 32'h0) begin
        wd_bad = 1'b1;
      end
      if (ifc.resp_valid) begin
        done = 1'b1;
        lat = k;
        got_err = ifc.resp_err;
        got_rdata = ifc.resp_rdata;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(exp_lat));
    chk($sformatf("v%0d_resp_err", idx), 32'(got_err), 32'(v.err));
    chk($sformatf("v%0d_resp_rdata", idx), got_rdata, v.rdata);
    chk($sformatf("v%0d_read_count", idx), 32'(rd_cnt), 32'(exp_rd_k != 0));
    chk($sformatf("v%0d_read_cycle", idx), 32'(rd_k), 32'(exp_rd_k));
    chk($sformatf("v%0d_write_count", idx), 32'(wr_cnt), 32'(exp_wr_k != 0));
    chk($sformatf("v%0d_write_cycle", idx), 32'(wr_k), 32'(exp_wr_k));
    if (exp_wr_k != 0) chk($sformatf("v%0d_write_data", idx), got_wd, v.wr_exp);
    chk($sformatf("v%0d_addr_bad", idx), 32'(addr_bad), 32'd0);
    chk($sformatf("v%0d_wdata_nonzero_outside_wr", idx), 32'(wd_bad), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_resp_single_pulse", idx), 32'(ifc.resp_valid), 32'd0);
    chk($sformatf("v%0d_ready_after", idx), 32'(ifc.req_ready), 32'd1);
    chk($sformatf("v%0d_resp_err_idle", idx), 32'(ifc.resp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ms;
`ifdef LSU_MISALIGN_CHECK_EN
    ms = 1'b1;
`else
    ms = 1'b0;
`endif
    //            we    f3      addr          wdata         err   rdata                        wr_exp
    vecs[0]  = mk(1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,                       32'hDEADBEEF);
    vecs[1]  = mk(1'b0, 3'b000, 32'h10,       32'h0,        1'b0, 32'hFFFFFFEF,                32'h0);
    vecs[2]  = mk(1'b0, 3'b100, 32'h10,       32'h0,        1'b0, 32'h000000EF,                32'h0);
    vecs[3]  = mk(1'b0, 3'b001, 32'h12,       32'h0,        1'b0, 32'hFFFFDEAD,                32'h0);
    vecs[4]  = mk(1'b0, 3'b101, 32'h12,       32'h0,        1'b0, 32'h0000DEAD,                32'h0);
    vecs[5]  = mk(1'b1, 3'b000, 32'h11,       32'h123456AA, 1'b0, 32'h0,                       32'h00DEADAA);
    vecs[6]  = mk(1'b0, 3'b010, 32'h10,       32'h0,        1'b0, 32'hDEADAAEF,                32'h0);
    vecs[7]  = mk(1'b0, 3'b010, 32'h12,       32'h0,        ms,   ms ? 32'h0 : 32'h0000DEAD,   32'h0);
    vecs[8]  = mk(1'b0, 3'b101, 32'h11,       32'h0,        ms,   ms ? 32'h0 : 32'h0000ADAA,   32'h0);
    vecs[9]  = mk(1'b1, 3'b001, 32'h12,       32'hFFFF1234, 1'b0, 32'h0,                       32'h00001234);
    vecs[10] = mk(1'b0, 3'b010, 32'h10,       32'h0,        1'b0, 32'h1234AAEF,                32'h0);
    vecs[11] = mk(1'b0, 3'b010, 32'h3FE,      32'h0,        1'b1, 32'h0,                       32'h0);
    vecs[12] = mk(1'b1, 3'b010, 32'hFFFFFFFE, 32'h11111111, 1'b1, 32'h0,                       32'h0);
    vecs[13] = mk(1'b0, 3'b011, 32'h10,       32'h0,        1'b1, 32'h0,                       32'h0);
    vecs[14] = mk(1'b1, 3'b100, 32'h10,       32'h22222222, 1'b1, 32'h0,                       32'h0);
    vecs[15] = mk(1'b0, 3'b010, 32'h3FC,      32'h0,        1'b0, 32'h0,                       32'h0);
    vecs[16] = mk(1'b1, 3'b000, 32'h3FF,      32'h000000C5, 1'b0, 32'h0,                       32'h000000C5);
    vecs[17] = mk(1'b0, 3'b100, 32'h3FF,      32'h0,        1'b0, 32'h000000C5,                32'h0);
    vecs[18] = mk(1'b0, 3'b000, 32'h3FF,      32'h0,        1'b0, 32'hFFFFFFC5,                32'h0);
    vecs[19] = mk(1'b0, 3'b001, 32'h3FF,      32'h0,        1'b1, 32'h0,                       32'h0);
    vecs[20] = mk(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,                       32'h0);
    vecs[21] = mk(1'b1, 3'b001, 32'h13,       32'h0000BEEF, ms,   32'h0,                       32'h0000BEEF);
    vecs[22] = mk(1'b0, 3'b010, 32'h10,       32'h0,        1'b0, ms ? 32'h1234AAEF : 32'hEF34AAEF, 32'h0);

    ifc.req_valid  = 1'b0;
    ifc.req_we     = 1'b0;
    ifc.req_funct3 = '0;
    ifc.req_addr   = '0;
    ifc.req_wdata  = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(ifc.req_ready), 32'd1);
    chk("reset_resp_valid", 32'(ifc.resp_valid), 32'd0);
    chk("reset_resp_err", 32'(ifc.resp_err), 32'd0);
    chk("reset_resp_rdata", ifc.resp_rdata, 32'h0);
    chk("reset_mem_read", 32'(ifc.mem_read), 32'd0);
    chk("reset_mem_write", 32'(ifc.mem_write), 32'd0);
    chk("reset_mem_addr", ifc.mem_addr, 32'h0);
    chk("reset_mem_wr_data", ifc.mem_wr_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset landing in the WR cycle of an SB must suppress the write and the response.
    @(negedge clk);
    ifc.req_valid  = 1'b1;
    ifc.req_we     = 1'b1;
    ifc.req_funct3 = 3'b000;
    ifc.req_addr   = 32'h20;
    ifc.req_wdata  = 32'h00000077;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    chk("abort_rmw_read", 32'(ifc.mem_read), 32'd1);
    @(posedge clk); #1;
    chk("abort_in_wr_before_rst", 32'(ifc.mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_write_gated", 32'(ifc.mem_write), 32'd0);
    chk("abort_mem_read_gated", 32'(ifc.mem_read), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 32'(ifc.req_ready), 32'd1);
    chk("abort_resp_valid", 32'(ifc.resp_valid), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (ifc.resp_valid || ifc.mem_write || ifc.mem_read) seen++;
      end
      chk("abort_no_late_activity", 32'(seen), 32'd0);
    end
    chk("abort_mem_untouched", 32'(mem[32'h20]), 32'h0);
    chk("abort_ready_later", 32'(ifc.req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit sitting in the MEM stage between the pipeline and the byte-addressed data memory; it is the initiator that drives that memory's `addr`, `wr_data`, `mem_read` and `mem_write` and consumes its combinational `rd_data`. It accepts one RV32I load/store request at a time, checks range and illegal encodings, and sign- or zero-extends load data. Because the memory only writes whole 32-bit words, SB and SH are performed as a read-modify-write sequence. The unit backpressures the pipeline through `req_ready`.

## Interface
- MEM_BYTES, 1024: data memory size in bytes; the range limit.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted when `req_valid & req_ready`.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: loads LB=000, LH=001, LW=010, LBU=100, LHU=101; stores SB=000, SH=001, SW=010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB or SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  request rejected; valid with `resp_valid`.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_addr  out  32  memory address.
- mem_wr_data  out  32  memory write data.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable; the memory writes at posedge.
- mem_rd_data  in  32  combinational read data from memory.

## Operation
- Request capture:
  - Accepting a request registers `req_we`, `req_funct3`, `req_addr` and `req_wdata`.
  - The unit then ignores request inputs until it returns to IDLE.
- FSM states and transitions:
  - IDLE: accept a request. On error go to RESP. Otherwise a load goes to LD, SW goes to WR, SB/SH go to RMW_RD.
  - LD: assert `mem_read` and capture the extended data. Go to RESP.
  - RMW_RD: assert `mem_read` and capture `mem_rd_data` into `word_q`. Go to WR.
  - WR: assert `mem_write` for exactly one cycle. Go to RESP.
  - RESP: drive `resp_valid`=1 for one cycle. Go to IDLE.
- `mem_addr` equals the registered address in every state.
- Write data:
  - SW: `mem_wr_data` = wdata.
  - SB: `mem_wr_data` = {word_q[31:8], wdata[7:0]}.
  - SH: `mem_wr_data` = {word_q[31:16], wdata[15:0]}.
  - Outside WR, `mem_wr_data` is 0.
- Load extension:
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Errors (`resp_err`=1, no memory access, `resp_rdata`=0):
  - Illegal funct3: loads 011/110/111; stores with funct3 other than 000/001/010.
  - Out of range: addr + access_size > MEM_BYTES, computed in 33 bits so wrap-around counts as out of range.
- `mem_read` and `mem_write` are forced to 0 in any cycle where `rst` is high.

## Timing
- Reset: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wr_data`=0.
- Latency, with the request accepted in cycle N:
  - Load: LD in N+1, `resp_valid` in N+2.
  - SW: WR in N+1, `resp_valid` in N+2.
  - SB/SH: RMW_RD in N+1, WR in N+2, `resp_valid` in N+3.
  - Error: `resp_valid` in N+1.
- `req_ready`=1 only in IDLE. There are no back-to-back accepts; throughput is at most one request per 2 cycles.
- `resp_rdata` and `resp_err` are valid only while `resp_valid`=1; they are 0 otherwise.
- Reset mid-operation:
  - `rst` in any state returns the FSM to IDLE at the next edge.
  - No `resp_valid` is issued for the aborted request.
  - An aborted RMW issues no write.

## Configuration
- LSU_MISALIGN_CHECK_EN
  - Defined: LH/LHU/SH with addr[0]≠0 and LW/SW with addr[1:0]≠0 are errors, with no memory access.
  - Undefined: misaligned accesses proceed normally. The memory is byte-addressed, so misaligned accesses are legal.
  - The range check applies in both builds.

## Structure
- `lsu_pkg`: the FSM state enum (IDLE, LD, RMW_RD, WR, RESP), the funct3 constants, and the access-size function (funct3 → 1/2/4).
- Sub-module `lsu_load_extend`: combinational; takes funct3 and a 32-bit word and returns the extended 32-bit result.
- The top level contains the FSM, the registers, the error check and the RMW merge.

## Test plan
- Reset, then SW 0x10 with 0xDEADBEEF → `mem_write` high only in N+1 with `mem_addr`=0x10 and `mem_wr_data`=0xDEADBEEF; `resp_valid` in N+2; `resp_err`=0.
- After that store:
  - LB 0x10 → 0xFFFFFFEF.
  - LBU 0x10 → 0x000000EF.
  - LH 0x12 → 0xFFFFDEAD.
  - LHU 0x12 → 0x0000DEAD.
  - Each response arrives in N+2.
- SB 0x11 with wdata 0x000000AA → read in N+1, write of 0x00DEADAA at 0x11 in N+2, `resp_valid` in N+3. A following LW 0x10 returns 0xDEADAAEF.
- LW 0x12:
  - With LSU_MISALIGN_CHECK_EN → `resp_err` in N+1, `mem_read` never asserted.
  - Without the macro → 0x0000DEAD (after the first scenario only).
- Range and encoding errors, each with no memory strobe:
  - LW 0x3FE → `resp_err`=1.
  - SW 0xFFFFFFFE → `resp_err`=1.
  - Load with funct3=011 → `resp_err`=1.
- Reset during WR of an SB → `mem_write`=0 in that cycle, IDLE next cycle, no `resp_valid`, `req_ready`=1.
